// File: rtl/fifo_uart_tx.sv
// Drains a synchronous byte FIFO and serialises each byte as a UART frame (idle-high line).
// Define PARITY_EN to append an even-parity bit after the data bits.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  // Wide enough to count both data bits and stop bits.
  localparam int unsigned BIT_W  = $clog2(DATA_W + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

`ifdef PARITY_EN
  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, STOP} state_t;
`endif

  state_t              state_q;
  logic [BAUD_W-1:0]   baud_q;
  logic [BIT_W-1:0]    bit_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [DATA_W-1:0]   shreg_next;
  logic                bit_end;
`ifdef PARITY_EN
  logic                parity_q;
`endif

  assign bit_end    = (baud_q == BAUD_LAST);
  assign shreg_next = shreg_q >> 1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      tx         <= 1'b1;
      fifo_rd    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      fifo_rd    <= 1'b0;
      frame_done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tx <= 1'b1;
          if (enable && !fifo_empty) begin
            state_q <= REQ;
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
          end
        end
        // FIFO registers the requested byte on this edge; capture it on the next.
        REQ: state_q <= LOAD;
        LOAD: begin
          shreg_q <= fifo_data;
          tx      <= 1'b0;
          baud_q  <= '0;
          state_q <= START;
`ifdef PARITY_EN
          parity_q <= ^fifo_data;
`endif
        end
        START: begin
          if (bit_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx      <= shreg_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == DATA_LAST) begin
              bit_q   <= '0;
`ifdef PARITY_EN
              tx      <= parity_q;
              state_q <= PARITY;
`else
              tx      <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              shreg_q <= shreg_next;
              tx      <= shreg_next[0];
              bit_q   <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx      <= 1'b1;
            state_q <= STOP;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`endif
        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == STOP_LAST) begin
              bit_q      <= '0;
              state_q    <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
